// File: rtl/chess_board_update.sv
// Board-state register for the chess engine: holds every piece's square and alive bit,
// and applies one confirmed move (with capture scan) per en rising edge.
module chess_board_update (
  input  logic        clk,
  input  logic        RST,
  input  logic        en,
  input  logic        player,
  input  logic [5:0]  move_input,
  input  logic [3:0]  piece_number,
  output logic [95:0] location_vectors_w,
  output logic [95:0] location_vectors_b,
  output logic [15:0] alive_vectors_w,
  output logic [15:0] alive_vectors_b,
  output logic [1:0]  dbg_state,
  output logic        output_player,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        en_prev;
  logic        en_rise;

  logic        lat_player;
  logic [3:0]  lat_piece;
  logic [5:0]  lat_dest;

  logic [3:0]  scan_idx;
  logic        cap_vld;
  logic [3:0]  cap_idx;

  logic [5:0]  loc_w [16];
  logic [5:0]  loc_b [16];
  logic [15:0] alive_w;
  logic [15:0] alive_b;

  logic        opp_alive;
  logic [5:0]  opp_sq;
  logic        scan_hit;
  logic        mover_alive;

  // Starting square {row, col} of piece idx for the given side (0 white, 1 black).
  function automatic logic [5:0] init_sq(input logic side, input logic [3:0] idx);
    logic [2:0] row;
    logic [2:0] col;
    case (idx)
      4'd8:    col = 3'd0;
      4'd9:    col = 3'd7;
      4'd10:   col = 3'd1;
      4'd11:   col = 3'd6;
      4'd12:   col = 3'd2;
      4'd13:   col = 3'd5;
      4'd14:   col = 3'd3;
      4'd15:   col = 3'd4;
      default: col = idx[2:0];
    endcase
    if (idx[3]) row = side ? 3'd7 : 3'd0;
    else        row = side ? 3'd6 : 3'd1;
    return {row, col};
  endfunction

  assign en_rise     = en & ~en_prev;
  assign opp_alive   = lat_player ? alive_w[scan_idx] : alive_b[scan_idx];
  assign opp_sq      = lat_player ? loc_w[scan_idx]   : loc_b[scan_idx];
  assign scan_hit    = opp_alive && (opp_sq == lat_dest);
  assign mover_alive = lat_player ? alive_b[lat_piece] : alive_w[lat_piece];

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (en_rise) next_state = SCAN;
      SCAN:    if (scan_idx == 4'd15) next_state = UPDATE;
      UPDATE:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      en_prev       <= 1'b0;
      lat_player    <= 1'b0;
      lat_piece     <= 4'd0;
      lat_dest      <= 6'd0;
      scan_idx      <= 4'd0;
      cap_vld       <= 1'b0;
      cap_idx       <= 4'd0;
      alive_w       <= '1;
      alive_b       <= '1;
      output_player <= 1'b0;
      done          <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        loc_w[i] <= init_sq(1'b0, i[3:0]);
        loc_b[i] <= init_sq(1'b1, i[3:0]);
      end
    end else begin
      en_prev <= en;
      done    <= (state == UPDATE);
      case (state)
        IDLE: begin
          if (en_rise) begin
            lat_player <= player;
            lat_piece  <= piece_number;
            lat_dest   <= move_input;
            scan_idx   <= 4'd0;
            cap_vld    <= 1'b0;
          end
        end
        SCAN: begin
          // Later matches overwrite earlier ones, so the highest matching index wins.
          if (scan_hit) begin
            cap_vld <= 1'b1;
            cap_idx <= scan_idx;
          end
          scan_idx <= scan_idx + 4'd1;
        end
        UPDATE: begin
          if (mover_alive) begin
            if (lat_player) begin
              loc_b[lat_piece] <= lat_dest;
              if (cap_vld) alive_w[cap_idx] <= 1'b0;
            end else begin
              loc_w[lat_piece] <= lat_dest;
              if (cap_vld) alive_b[cap_idx] <= 1'b0;
            end
            output_player <= ~lat_player;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    location_vectors_w = '0;
    location_vectors_b = '0;
    for (int i = 0; i < 16; i++) begin
      location_vectors_w[6*i +: 6] = loc_w[i];
      location_vectors_b[6*i +: 6] = loc_b[i];
    end
  end

  assign alive_vectors_w = alive_w;
  assign alive_vectors_b = alive_b;
  assign dbg_state       = state;

endmodule

// File: tb/tb_chess_board_update.sv
// Self-checking bench for chess_board_update: random and directed moves against
// a square/alive-list reference model of the board.
module tb_chess_board_update;

  logic        clk;
  logic        RST;
  logic        en;
  logic        player;
  logic [5:0]  move_input;
  logic [3:0]  piece_number;
  logic [95:0] location_vectors_w;
  logic [95:0] location_vectors_b;
  logic [15:0] alive_vectors_w;
  logic [15:0] alive_vectors_b;
  logic [1:0]  dbg_state;
  logic        output_player;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [5:0]  m_loc_w [16];
  logic [5:0]  m_loc_b [16];
  logic [15:0] m_alive_w;
  logic [15:0] m_alive_b;
  logic        m_player;
  int          col_of [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 7, 1, 6, 2, 5, 3, 4};

  chess_board_update dut (
    .clk                (clk),
    .RST                (RST),
    .en                 (en),
    .player             (player),
    .move_input         (move_input),
    .piece_number       (piece_number),
    .location_vectors_w (location_vectors_w),
    .location_vectors_b (location_vectors_b),
    .alive_vectors_w    (alive_vectors_w),
    .alive_vectors_b    (alive_vectors_b),
    .dbg_state          (dbg_state),
    .output_player      (output_player),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_loc_w[i] = 6'((i < 8 ? 1 : 0) * 8 + col_of[i]);
      m_loc_b[i] = 6'((i < 8 ? 6 : 7) * 8 + col_of[i]);
    end
    m_alive_w = 16'hFFFF;
    m_alive_b = 16'hFFFF;
    m_player  = 1'b0;
  endfunction

  function automatic void model_move(input bit p, input int pc, input logic [5:0] d);
    int cap;
    cap = -1;
    if (p == 1'b0 && m_alive_w[pc]) begin
      for (int i = 0; i < 16; i++) if (m_alive_b[i] && m_loc_b[i] == d) cap = i;
      m_loc_w[pc] = d;
      if (cap >= 0) m_alive_b[cap] = 1'b0;
      m_player = 1'b1;
    end else if (p == 1'b1 && m_alive_b[pc]) begin
      for (int i = 0; i < 16; i++) if (m_alive_w[i] && m_loc_w[i] == d) cap = i;
      m_loc_b[pc] = d;
      if (cap >= 0) m_alive_w[cap] = 1'b0;
      m_player = 1'b0;
    end
  endfunction

  function automatic logic [95:0] pack_w();
    logic [95:0] v;
    for (int i = 0; i < 16; i++) v[6*i +: 6] = m_loc_w[i];
    return v;
  endfunction

  function automatic logic [95:0] pack_b();
    logic [95:0] v;
    for (int i = 0; i < 16; i++) v[6*i +: 6] = m_loc_b[i];
    return v;
  endfunction

  // Pulses en for one clock and reports the cycle (0 = request cycle) and count of done pulses.
  task automatic do_move(input bit p, input logic [3:0] pc, input logic [5:0] d,
                         output int done_cyc, output int done_cnt);
    @(negedge clk);
    player = p; piece_number = pc; move_input = d; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    done_cyc = -1;
    done_cnt = 0;
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
  endtask

  task automatic test_reset();
    en = 1'b0; player = 1'b0; piece_number = 4'd0; move_input = 6'd0;
    RST = 1'b0;
    repeat (3) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    model_reset();
    n_checks++;
    if (location_vectors_w[5:0] !== 6'h08) begin n_fail++; $display("FAIL reset_w_pawn0: got %h want 08", location_vectors_w[5:0]); end
    n_checks++;
    if (location_vectors_w[95:90] !== 6'h04) begin n_fail++; $display("FAIL reset_w_king: got %h want 04", location_vectors_w[95:90]); end
    n_checks++;
    if (location_vectors_b[95:90] !== 6'h3C) begin n_fail++; $display("FAIL reset_b_king: got %h want 3c", location_vectors_b[95:90]); end
    n_checks++;
    if (location_vectors_b[5:0] !== 6'h30) begin n_fail++; $display("FAIL reset_b_pawn0: got %h want 30", location_vectors_b[5:0]); end
    n_checks++;
    if (alive_vectors_w !== 16'hFFFF || alive_vectors_b !== 16'hFFFF) begin
      n_fail++; $display("FAIL reset_alive: got %h %h want ffff ffff", alive_vectors_w, alive_vectors_b);
    end
    n_checks++;
    if (output_player !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got player=%b done=%b state=%0d want 0 0 0", output_player, done, dbg_state);
    end
    n_checks++;
    if (location_vectors_w !== pack_w() || location_vectors_b !== pack_b()) begin
      n_fail++; $display("FAIL reset_board: got %h %h want %h %h", location_vectors_w, location_vectors_b, pack_w(), pack_b());
    end
  endtask

  task automatic test_simple_move();
    int dc, dn;
    do_move(1'b0, 4'd4, 6'h1C, dc, dn);
    model_move(1'b0, 4, 6'h1C);
    n_checks++;
    if (dc !== 18 || dn !== 1) begin n_fail++; $display("FAIL simple_done_timing: got cycle %0d count %0d want 18 1", dc, dn); end
    n_checks++;
    if (location_vectors_w[29:24] !== 6'h1C) begin n_fail++; $display("FAIL simple_dest: got %h want 1c", location_vectors_w[29:24]); end
    n_checks++;
    if (output_player !== 1'b1) begin n_fail++; $display("FAIL simple_player: got %b want 1", output_player); end
    n_checks++;
    if (alive_vectors_w !== 16'hFFFF || alive_vectors_b !== 16'hFFFF) begin
      n_fail++; $display("FAIL simple_alive: got %h %h want ffff ffff", alive_vectors_w, alive_vectors_b);
    end
    n_checks++;
    if (location_vectors_w !== pack_w() || location_vectors_b !== pack_b()) begin
      n_fail++; $display("FAIL simple_board: got %h %h want %h %h", location_vectors_w, location_vectors_b, pack_w(), pack_b());
    end
  endtask

  task automatic test_capture();
    int dc, dn;
    do_move(1'b1, 4'd3, 6'h23, dc, dn);
    model_move(1'b1, 3, 6'h23);
    n_checks++;
    if (location_vectors_b[23:18] !== 6'h23 || output_player !== 1'b0) begin
      n_fail++; $display("FAIL capture_setup: got %h player=%b want 23 0", location_vectors_b[23:18], output_player);
    end
    do_move(1'b0, 4'd4, 6'h23, dc, dn);
    model_move(1'b0, 4, 6'h23);
    n_checks++;
    if (alive_vectors_b[3] !== 1'b0) begin n_fail++; $display("FAIL capture_alive: got %b want 0", alive_vectors_b[3]); end
    n_checks++;
    if (location_vectors_b[23:18] !== 6'h23) begin n_fail++; $display("FAIL capture_victim_loc: got %h want 23", location_vectors_b[23:18]); end
    n_checks++;
    if (location_vectors_w[29:24] !== 6'h23 || output_player !== 1'b1) begin
      n_fail++; $display("FAIL capture_mover: got %h player=%b want 23 1", location_vectors_w[29:24], output_player);
    end
    n_checks++;
    if (alive_vectors_b !== m_alive_b || alive_vectors_w !== m_alive_w) begin
      n_fail++; $display("FAIL capture_alive_all: got %h %h want %h %h", alive_vectors_w, alive_vectors_b, m_alive_w, m_alive_b);
    end
  endtask

  task automatic test_dead_piece();
    int dc, dn;
    logic [95:0] w0, b0;
    logic [15:0] aw0, ab0;
    w0 = location_vectors_w; b0 = location_vectors_b; aw0 = alive_vectors_w; ab0 = alive_vectors_b;
    do_move(1'b1, 4'd3, 6'h10, dc, dn);
    model_move(1'b1, 3, 6'h10);
    n_checks++;
    if (dc !== 18 || dn !== 1) begin n_fail++; $display("FAIL dead_done: got cycle %0d count %0d want 18 1", dc, dn); end
    n_checks++;
    if (location_vectors_w !== w0 || location_vectors_b !== b0 || alive_vectors_w !== aw0 || alive_vectors_b !== ab0) begin
      n_fail++; $display("FAIL dead_unchanged: got %h %h want %h %h", location_vectors_b, alive_vectors_w, b0, aw0);
    end
    n_checks++;
    if (output_player !== 1'b1) begin n_fail++; $display("FAIL dead_player: got %b want 1", output_player); end
  endtask

  task automatic test_held_en();
    int dn, changes;
    logic [95:0] prev;
    dn = 0; changes = 0;
    @(negedge clk);
    player = 1'b0; piece_number = 4'd0; move_input = 6'h18; en = 1'b1;
    prev = location_vectors_w;
    for (int c = 0; c < 75; c++) begin
      @(negedge clk);
      if (c == 49) en = 1'b0;
      if (done === 1'b1) dn++;
      if (location_vectors_w !== prev) changes++;
      prev = location_vectors_w;
    end
    model_move(1'b0, 0, 6'h18);
    n_checks++;
    if (dn !== 1 || changes !== 1) begin n_fail++; $display("FAIL held_en: got done=%0d changes=%0d want 1 1", dn, changes); end
    n_checks++;
    if (location_vectors_w !== pack_w()) begin n_fail++; $display("FAIL held_en_board: got %h want %h", location_vectors_w, pack_w()); end
  endtask

  task automatic test_random();
    int dc, dn;
    bit p;
    logic [3:0] pc;
    logic [5:0] d;
    int r;
    for (int k = 0; k < 30; k++) begin
      p  = 1'($urandom_range(1, 0));
      pc = 4'($urandom_range(15, 0));
      r  = $urandom_range(2, 0);
      if (r == 0)      d = p ? m_loc_w[$urandom_range(15, 0)] : m_loc_b[$urandom_range(15, 0)];
      else if (r == 1) d = p ? m_loc_b[$urandom_range(15, 0)] : m_loc_w[$urandom_range(15, 0)];
      else             d = 6'($urandom_range(63, 0));
      do_move(p, pc, d, dc, dn);
      model_move(p, pc, d);
      n_checks++;
      if (dc !== 18 || dn !== 1 || location_vectors_w !== pack_w() || location_vectors_b !== pack_b() ||
          alive_vectors_w !== m_alive_w || alive_vectors_b !== m_alive_b || output_player !== m_player) begin
        n_fail++;
        $display("FAIL random_move%0d: got cyc=%0d cnt=%0d aw=%h ab=%h pl=%b want 18 1 %h %h %b",
                 k, dc, dn, alive_vectors_w, alive_vectors_b, output_player, m_alive_w, m_alive_b, m_player);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int dn;
    @(negedge clk);
    player = 1'b0; piece_number = 4'd6; move_input = 6'h2E; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++;
    if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL midscan_state_before: got %0d want 1", dbg_state); end
    RST = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dbg_state !== 2'd0 || done !== 1'b0 || output_player !== 1'b0) begin
      n_fail++; $display("FAIL midscan_ctrl: got state=%0d done=%b pl=%b want 0 0 0", dbg_state, done, output_player);
    end
    n_checks++;
    if (location_vectors_w !== pack_w() || location_vectors_b !== pack_b() ||
        alive_vectors_w !== 16'hFFFF || alive_vectors_b !== 16'hFFFF) begin
      n_fail++; $display("FAIL midscan_board: got %h %h want %h %h", location_vectors_w, location_vectors_b, pack_w(), pack_b());
    end
    repeat (2) @(negedge clk);
    RST = 1'b1;
    dn = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    n_checks++;
    if (dn !== 0 || location_vectors_w !== pack_w()) begin n_fail++; $display("FAIL midscan_no_done: got done=%0d want 0", dn); end
  endtask

  task automatic test_en_high_at_release();
    int dc, dn;
    @(negedge clk);
    RST = 1'b0;
    player = 1'b1; piece_number = 4'd0; move_input = 6'h28; en = 1'b1;
    @(negedge clk);
    RST = 1'b1;
    model_reset();
    @(negedge clk);
    en = 1'b0;
    dc = -1; dn = 0;
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) @(negedge clk);
      if (done === 1'b1) begin
        dn++;
        if (dc < 0) dc = c;
      end
    end
    model_move(1'b1, 0, 6'h28);
    n_checks++;
    if (dc !== 18 || dn !== 1) begin n_fail++; $display("FAIL release_edge_done: got cycle %0d count %0d want 18 1", dc, dn); end
    n_checks++;
    if (location_vectors_b !== pack_b() || output_player !== 1'b0) begin
      n_fail++; $display("FAIL release_edge_board: got %h pl=%b want %h 0", location_vectors_b, output_player, pack_b());
    end
  endtask

  initial begin
    RST = 1'b0; en = 1'b0; player = 1'b0; piece_number = 4'd0; move_input = 6'd0;
    test_reset();
    test_simple_move();
    test_capture();
    test_dead_piece();
    test_held_en();
    test_random();
    test_reset_mid_scan();
    test_en_high_at_release();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chess_board_update.md
# chess_board_update

Board-state register for the chess engine. It holds the 6-bit square of all 32 pieces and one alive bit per piece. On a confirmed move from the cursor/LCD front end it relocates the selected piece, captures any opposing piece on the destination square, and hands the turn to the other side. Its outputs feed move generation and the LCD renderer.

## Interface
- No parameters.
- clk  in  1  system clock (50 MHz); all state on rising edge.
- RST  in  1  asynchronous, active-low reset; restores initial board.
- en  in  1  move-confirm request; acted on at its rising edge.
- player  in  1  side to move (0 white, 1 black); sampled when a request is accepted.
- move_input  in  6  destination square {row[2:0], col[2:0]}.
- piece_number  in  4  index of the piece to move, within the mover's side.
- location_vectors_w  out  96  white squares; piece i at [6i+5:6i].
- location_vectors_b  out  96  black squares, same packing.
- alive_vectors_w  out  16  white alive bits; bit i is piece i.
- alive_vectors_b  out  16  black alive bits.
- dbg_state  out  2  current FSM state code.
- output_player  out  1  side to move next.
- done  out  1  one-cycle pulse when an update completes.

## Operation
- Piece index map, identical for both sides:
  - 0–7: pawns in columns 0–7.
  - 8, 9: rooks, columns 0, 7.
  - 10, 11: knights, columns 1, 6.
  - 12, 13: bishops, columns 2, 5.
  - 14: queen, column 3.
  - 15: king, column 4.
- Initial rows:
  - White: pawns on row 1, other pieces on row 0.
  - Black: pawns on row 6, other pieces on row 7.
- Reset values:
  - All alive bits = 1.
  - output_player = 0; done = 0; dbg_state = 0.
  - Example squares: white pawn 0 = 0x08, white king = 0x04, black pawn 0 = 0x30, black king = 0x3C.
- FSM states: IDLE (0), SCAN (1), UPDATE (2), DONE (3).
- IDLE:
  - On a rising edge of en (en = 1 now, 0 on the previous clock), latch player, piece_number and move_input.
  - Clear the scan index, then go to SCAN.
- SCAN:
  - Examine one opposing piece per cycle, index 0..15.
  - If that piece is alive and its square equals the latched destination, record it as the capture target. With several matches, the last match wins.
  - After index 15, go to UPDATE.
- UPDATE, when the mover's piece piece_number is alive:
  - Write the destination into that piece's location field.
  - Clear the alive bit of any recorded capture target; its location field is left unchanged.
  - output_player <= ~latched player.
- UPDATE, when the mover's piece is dead:
  - Vectors and output_player are left unchanged.
- UPDATE always proceeds to DONE.
- DONE: assert done for this cycle only, then return to IDLE.
- No legality checking is done here; move legality is upstream. A destination that holds one of the mover's own pieces is accepted, and that own piece is left untouched.
- Rising edges of en outside IDLE are ignored and not queued.
- en held high continuously yields exactly one move.

## Timing
- Cycle 0: en rising edge sampled in IDLE.
- Cycles 1–16: SCAN.
- Cycle 17: UPDATE. Vectors and output_player change at the end of this cycle.
- Cycle 18: DONE, with done = 1.
- Cycle 19: IDLE. A new rising edge of en is accepted here or later.
- All outputs are registered.
- RST low at any time, including mid-SCAN, immediately forces:
  - initial board;
  - IDLE state;
  - done = 0.
- The en edge detector also resets, with previous en = 0. An en already high when RST releases therefore counts as a rising edge on the first clock.

## Test plan
- Reset: assert RST low, then release. Check location_vectors_w[5:0] = 0x08, [95:90] = 0x04, location_vectors_b[95:90] = 0x3C, both alive vectors = 0xFFFF, output_player = 0, done = 0.
- Simple move: player = 0, piece_number = 4, move_input = 0x1C, pulse en.
  - done high exactly at cycle 18.
  - location_vectors_w[29:24] = 0x1C.
  - output_player = 1; alive vectors unchanged.
- Capture: move black pawn 3 (player = 1) to 0x23. Then move white pawn 4 (player = 0), now at 0x1C, to 0x23.
  - alive_vectors_b[3] = 0; location_vectors_b[23:18] stays 0x23.
  - location_vectors_w[29:24] = 0x23; output_player = 1.
- Dead piece: move black piece 3 (player = 1) to 0x10 after it is captured.
  - done pulses; vectors unchanged; output_player stays 1.
- en held high for 50 cycles: exactly one done pulse and one board change.
- Reset mid-operation: drive RST low at cycle 8 of SCAN.
  - Board returns to initial; dbg_state = 0; no done pulse.
